// File: rtl/axi4m_fifo_reader.sv
// AXI4 read master: streams read_num beats from read_addr into a FIFO write port as INCR bursts.
// Latency: R beat to buf_we/buf_dout is 1 cycle (registered); kick to first AR is 3 cycles.
// Backpressure: buf_full drops rready combinationally; AR issue stalls at MAX_OUTSTANDING bursts.
// Build option: define AXI4M_FIFO_4K_SPLIT_EN to cut bursts at 4 KB boundaries.
module axi4m_fifo_reader #(
  parameter int C_M_AXI_ID_WIDTH   = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int MAX_BURST_LEN      = 64,
  parameter int MAX_OUTSTANDING    = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          kick,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  input  logic [31:0]                   read_num,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] read_addr,
  output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arlock,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_rid,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  input  logic                          buf_full,
  output logic [C_M_AXI_DATA_WIDTH-1:0] buf_dout,
  output logic                          buf_we
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int BYTES = DW / 8;
  localparam int SZ    = $clog2(BYTES);

  typedef enum logic [2:0] {S_IDLE, S_KICK, S_CALC, S_ISSUE, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [31:0]     remain_q, remain_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [7:0]      arlen_q, arlen_d;
  logic [8:0]      len_q, len_d;
  logic [3:0]      outst_q, outst_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            buf_we_q, buf_we_d;
  logic [DW-1:0]   buf_dout_q, buf_dout_d;
  logic [31:0]     len_c;
  logic [31:0]     remain_after;
  logic            ar_hs, r_hs, rlast_hs;
  logic            unused_rid;

  // Responses are always ID 0, so rid carries no information here.
  assign unused_rid = &{1'b0, m_axi_rid};

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0010;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_q == S_ISSUE);
  assign m_axi_rready  = busy & ~buf_full;
  assign buf_dout      = buf_dout_q;
  assign buf_we        = buf_we_q;

  assign ar_hs        = m_axi_arvalid & m_axi_arready;
  assign r_hs         = m_axi_rvalid & m_axi_rready;
  assign rlast_hs     = r_hs & m_axi_rlast;
  assign remain_after = remain_q - {23'd0, len_q};

`ifdef AXI4M_FIFO_4K_SPLIT_EN
  logic [12:0] bytes_4k;
  logic [31:0] beats_4k;
  assign bytes_4k = 13'h1000 - {1'b0, addr_q[11:0]};
  assign beats_4k = 32'(bytes_4k >> SZ);
`endif

  // Next burst length: remaining beats capped by the burst limit (and the 4 KB page end when enabled).
  always_comb begin
    len_c = (remain_q < 32'(MAX_BURST_LEN)) ? remain_q : 32'(MAX_BURST_LEN);
`ifdef AXI4M_FIFO_4K_SPLIT_EN
    if (beats_4k < len_c) len_c = beats_4k;
`endif
  end

  // Job sequencing, burst bookkeeping and the registered FIFO write path.
  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    addr_d     = addr_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    len_d      = len_q;
    err_d      = err_q;
    done_d     = 1'b0;
    outst_d    = outst_q + {3'd0, ar_hs} - {3'd0, rlast_hs};
    buf_we_d   = r_hs;
    buf_dout_d = r_hs ? m_axi_rdata : '0;

    case (state_q)
      S_IDLE: begin
        if (kick) begin
          remain_d = read_num;
          addr_d   = read_addr & ~AW'(BYTES - 1);
          err_d    = 1'b0;
          state_d  = S_KICK;
        end
      end
      S_KICK: begin
        if (remain_q == 32'd0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (outst_q != 4'(MAX_OUTSTANDING)) begin
          araddr_d = addr_q;
          arlen_d  = 8'(len_c - 32'd1);
          len_d    = len_c[8:0];
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (m_axi_arready) begin
          remain_d = remain_after;
          addr_d   = addr_q + (AW'(len_q) << SZ);
          state_d  = (remain_after == 32'd0) ? S_DRAIN : S_CALC;
        end
      end
      S_DRAIN: begin
        if (outst_q == 4'd0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Error responses are flagged but the beat is still forwarded.
    if (r_hs && (m_axi_rresp != 2'b00)) err_d = 1'b1;
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      remain_q   <= '0;
      addr_q     <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      len_q      <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      buf_we_q   <= 1'b0;
      buf_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      addr_q     <= addr_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      len_q      <= len_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
      done_q     <= done_d;
      buf_we_q   <= buf_we_d;
      buf_dout_q <= buf_dout_d;
    end
  end

endmodule

// File: tb/tb_axi4m_fifo_reader.sv
// Directed bench for axi4m_fifo_reader: table of read jobs plus hand sequences for
// zero-length jobs and the outstanding-burst limit, against a behavioural AXI slave
// whose read data equals the byte address of each beat.
module tb_axi4m_fifo_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        kick;
  logic        busy, done, err;
  logic [31:0] read_num;
  logic [31:0] read_addr;
  logic [3:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic        m_axi_rready;
  logic [3:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        buf_full;
  logic [31:0] buf_dout;
  logic        buf_we;

  always #5 clk = ~clk;

  axi4m_fifo_reader #(
    .C_M_AXI_ID_WIDTH(4), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
    .MAX_BURST_LEN(64), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .kick(kick), .busy(busy), .done(done), .err(err),
    .read_num(read_num), .read_addr(read_addr),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rready(m_axi_rready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .buf_full(buf_full), .buf_dout(buf_dout), .buf_we(buf_we)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] q_addr[$];
  int          q_len[$];
  bit          r_hold = 1'b0;
  int          err_at = -1;
  int          n_rbeat = 0;
  int          rrem = 0;
  logic [31:0] raddr = 0;
  int          scyc = 0;

  initial begin
    m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    m_axi_arready = 0; m_axi_rid = 0;
    forever begin
      @(posedge clk);
      if (m_axi_arvalid && m_axi_arready) begin
        q_addr.push_back(m_axi_araddr);
        q_len.push_back(int'(m_axi_arlen));
      end
      if (m_axi_rvalid && m_axi_rready) begin
        rrem--; raddr += 4; n_rbeat++;
      end
      #1;
      m_axi_arready = ((scyc % 3) != 2);
      scyc++;
      if (rrem == 0 && q_addr.size() > 0 && !r_hold) begin
        raddr = q_addr.pop_front();
        rrem  = q_len.pop_front() + 1;
      end
      if (rrem > 0 && !r_hold) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = raddr;
        m_axi_rlast  = (rrem == 1);
        m_axi_rresp  = (n_rbeat == err_at) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] ar_addr[64];
  int          ar_len[64];
  int          ar_cyc[64];
  int          rl_cyc[64];
  logic [31:0] beat_log[2048];
  int n_ar = 0, n_rl = 0, n_beat = 0, n_done = 0, cyc = 0;
  int outst = 0, max_outst = 0;
  int rr_bad = 0, stab_bad = 0, zero_bad = 0;
  bit pend_ar = 0;
  logic [31:0] pa;
  logic [7:0]  pl;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (m_axi_arvalid && m_axi_arready && n_ar < 64) begin
      ar_addr[n_ar] = m_axi_araddr; ar_len[n_ar] = int'(m_axi_arlen);
      ar_cyc[n_ar] = cyc; n_ar++; outst++;
    end
    if (m_axi_rvalid && m_axi_rready && m_axi_rlast && n_rl < 64) begin
      rl_cyc[n_rl] = cyc; n_rl++; outst--;
    end
    if (outst > max_outst) max_outst = outst;
    if (buf_we && n_beat < 2048) begin beat_log[n_beat] = buf_dout; n_beat++; end
    if (!buf_we && buf_dout != 0) zero_bad++;
    if (done) n_done++;
    if (reset_n && (m_axi_rready !== (busy & ~buf_full))) rr_bad++;
    if (pend_ar && (!m_axi_arvalid || m_axi_araddr != pa || m_axi_arlen != pl)) stab_bad++;
    pend_ar = m_axi_arvalid && !m_axi_arready;
    pa = m_axi_araddr; pl = m_axi_arlen;
  end

  // Random FIFO-full pressure, enabled per job.
  bit full_rnd = 0;
  initial begin
    buf_full = 0;
    forever begin
      @(negedge clk);
      buf_full = full_rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // ---------------- job helpers ----------------
  task automatic start(input logic [31:0] num, input logic [31:0] a);
    @(negedge clk);
    read_num = num; read_addr = a; kick = 1'b1;
    @(negedge clk);
    kick = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit got = 0;
    for (int k = 0; k < 4000; k++) begin
      if (done) begin got = 1; break; end
      @(negedge clk);
    end
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
  endtask

  function automatic int data_errs(input int base_idx, input int num, input logic [31:0] base);
    int e = 0;
    for (int i = 0; i < num; i++)
      if (base_idx + i >= 2048 || beat_log[base_idx + i] != base + 32'(4 * i)) e++;
    return e;
  endfunction

  typedef struct {
    logic [31:0] num;
    logic [31:0] addr;
    logic [31:0] base;
    int          nar;
    logic [31:0] a0;
    int          l0;
    logic [31:0] a1;
    int          l1;
    int          err_off;
    bit          rnd_full;
    bit          exp_err;
  } vec_t;

  vec_t vt[7];

  initial begin
    int ab, bb, db, rb;
    vt[0] = '{32'd100, 32'h1000, 32'h1000, 2, 32'h1000, 63, 32'h1100, 35, -1, 1'b0, 1'b0};
    vt[1] = '{32'd0,   32'h2000, 32'h2000, 0, 32'h0,    0,  32'h0,    0,  -1, 1'b0, 1'b0};
    vt[2] = '{32'd128, 32'h2000, 32'h2000, 2, 32'h2000, 63, 32'h2100, 63, -1, 1'b1, 1'b0};
    vt[3] = '{32'd10,  32'h3000, 32'h3000, 1, 32'h3000, 9,  32'h0,    0,   5, 1'b0, 1'b1};
`ifdef AXI4M_FIFO_4K_SPLIT_EN
    vt[4] = '{32'd16,  32'h0FF0, 32'h0FF0, 2, 32'h0FF0, 3,  32'h1000, 11, -1, 1'b0, 1'b0};
`else
    vt[4] = '{32'd16,  32'h0FF0, 32'h0FF0, 1, 32'h0FF0, 15, 32'h0,    0,  -1, 1'b0, 1'b0};
`endif
    vt[5] = '{32'd1,   32'h4003, 32'h4000, 1, 32'h4000, 0,  32'h0,    0,  -1, 1'b0, 1'b0};
    vt[6] = '{32'd300, 32'h6000, 32'h6000, 5, 32'h6000, 63, 32'h6100, 63, -1, 1'b1, 1'b0};

    reset_n = 0; kick = 0; read_num = 0; read_addr = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_arvalid", 64'(m_axi_arvalid), 0);
    chk("rst_araddr_arlen", {24'd0, m_axi_arlen, m_axi_araddr}, 0);
    chk("rst_buf", {31'd0, buf_we, buf_dout}, 0);
    reset_n = 1;
    repeat (2) @(negedge clk);
    chk("ar_fixed_fields", {m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot},
        {4'd0, 3'd2, 2'b01, 1'b0, 4'b0010, 3'b000});

    // Zero-length job: done two cycles after the kick cycle, no AR.
    ab = n_ar;
    start(32'd0, 32'h8000);
    chk("z_busy_c1", 64'(busy), 1);
    chk("z_done_c1", 64'(done), 0);
    @(negedge clk);
    chk("z_busy_c2", 64'(busy), 0);
    chk("z_done_c2", 64'(done), 1);
    @(negedge clk);
    chk("z_done_c3", 64'(done), 0);
    chk("z_no_ar", 64'(n_ar - ab), 0);

    // Kick while busy must not restart or alter the job.
    start(32'd4, 32'h7000);
    read_num = 32'd50; read_addr = 32'h9000; kick = 1'b1;
    @(negedge clk); kick = 1'b0;
    wait_done("kb");
    repeat (3) @(negedge clk);
    chk("kb_ar_addr", 64'(ar_addr[n_ar - 1]), 64'h7000);
    chk("kb_ar_len", 64'(ar_len[n_ar - 1]), 3);

    for (int v = 0; v < 7; v++) begin
      ab = n_ar; bb = n_beat; db = n_done;
      err_at   = (vt[v].err_off >= 0) ? n_rbeat + vt[v].err_off : -1;
      full_rnd = vt[v].rnd_full;
      start(vt[v].num, vt[v].addr);
      chk($sformatf("v%0d_err_clr", v), 64'(err), 0);
      wait_done($sformatf("v%0d", v));
      repeat (4) @(negedge clk);
      full_rnd = 0;
      chk($sformatf("v%0d_ndone", v), 64'(n_done - db), 1);
      chk($sformatf("v%0d_nar", v), 64'(n_ar - ab), 64'(vt[v].nar));
      if (vt[v].nar >= 1) begin
        chk($sformatf("v%0d_ar0_addr", v), 64'(ar_addr[ab]), 64'(vt[v].a0));
        chk($sformatf("v%0d_ar0_len", v), 64'(ar_len[ab]), 64'(vt[v].l0));
      end
      if (vt[v].nar >= 2) begin
        chk($sformatf("v%0d_ar1_addr", v), 64'(ar_addr[ab + 1]), 64'(vt[v].a1));
        chk($sformatf("v%0d_ar1_len", v), 64'(ar_len[ab + 1]), 64'(vt[v].l1));
      end
      chk($sformatf("v%0d_beats", v), 64'(n_beat - bb), 64'(vt[v].num));
      chk($sformatf("v%0d_data_errs", v), 64'(data_errs(bb, int'(vt[v].num), vt[v].base)), 0);
      chk($sformatf("v%0d_err", v), 64'(err), 64'(vt[v].exp_err));
      chk($sformatf("v%0d_busy_end", v), 64'(busy), 0);
    end
    err_at = -1;

    // Outstanding limit: slave withholds data, only two ARs may go out.
    ab = n_ar; bb = n_beat; rb = n_rl;
    r_hold = 1;
    start(32'd256, 32'h5000);
    repeat (40) @(negedge clk);
    chk("ol_nar_held", 64'(n_ar - ab), 2);
    chk("ol_arvalid_low", 64'(m_axi_arvalid), 0);
    r_hold = 0;
    wait_done("ol");
    repeat (3) @(negedge clk);
    chk("ol_nar_total", 64'(n_ar - ab), 4);
    chk("ol_ar2_after_rlast", 64'(ar_cyc[ab + 2] > rl_cyc[rb]), 1);
    chk("ol_beats", 64'(n_beat - bb), 256);
    chk("ol_data_errs", 64'(data_errs(bb, 256, 32'h5000)), 0);

    chk("max_outstanding", 64'(max_outst), 2);
    chk("rready_rule_errs", 64'(rr_bad), 0);
    chk("ar_stability_errs", 64'(stab_bad), 0);
    chk("buf_dout_idle_errs", 64'(zero_bad), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
